// File: rtl/uc_pkg.sv
// Shared definitions for the multicycle RV32I control unit: opcodes, FSM states,
// opcode classes and the ALU / PC / register-file select codes.
package uc_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    INIT, FETCH, DECODE, EXEC, MEM, WB, TRAP
  } state_e;

  typedef enum logic [3:0] {
    CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH,
    CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_ILLEGAL
  } op_class_e;

  localparam int ALU_CMD_R      = 0;
  localparam int ALU_CMD_I      = 1;
  localparam int ALU_CMD_MEM    = 2;
  localparam int ALU_CMD_BRANCH = 3;
  localparam int ALU_CMD_LUI    = 4;
  localparam int ALU_CMD_AUIPC  = 5;
  localparam int ALU_CMD_JUMP   = 6;

  localparam logic [1:0] PC_SRC_SEQ = 2'b00;
  localparam logic [1:0] PC_SRC_IMM = 2'b01;
  localparam logic [1:0] PC_SRC_ALU = 2'b10;

  localparam logic [1:0] RF_SRC_ALU = 2'b00;
  localparam logic [1:0] RF_SRC_MEM = 2'b01;
  localparam logic [1:0] RF_SRC_PC4 = 2'b10;

endpackage

// File: rtl/uc_decode.sv
// Combinational opcode decoder: instruction class, ALU command, ALU operand
// select and illegal-opcode flag.
module uc_decode
  import uc_pkg::*;
#(
  parameter int ALU_CMD_W = 4
) (
  input  logic [6:0]           opcode,
  output op_class_e            op_class,
  output logic [ALU_CMD_W-1:0] alu_cmd,
  output logic                 alu_src,
  output logic                 illegal
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    alu_cmd  = ALU_CMD_W'(ALU_CMD_R);
    alu_src  = 1'b0;
    case (opcode)
      OP_R:      begin op_class = CLS_R;      alu_cmd = ALU_CMD_W'(ALU_CMD_R);                    end
      OP_I:      begin op_class = CLS_I;      alu_cmd = ALU_CMD_W'(ALU_CMD_I);      alu_src = 1'b1; end
      OP_LOAD:   begin op_class = CLS_LOAD;   alu_cmd = ALU_CMD_W'(ALU_CMD_MEM);    alu_src = 1'b1; end
      OP_STORE:  begin op_class = CLS_STORE;  alu_cmd = ALU_CMD_W'(ALU_CMD_MEM);    alu_src = 1'b1; end
      OP_BRANCH: begin op_class = CLS_BRANCH; alu_cmd = ALU_CMD_W'(ALU_CMD_BRANCH);                 end
      OP_LUI:    begin op_class = CLS_LUI;    alu_cmd = ALU_CMD_W'(ALU_CMD_LUI);    alu_src = 1'b1; end
      OP_AUIPC:  begin op_class = CLS_AUIPC;  alu_cmd = ALU_CMD_W'(ALU_CMD_AUIPC);  alu_src = 1'b1; end
      OP_JAL:    begin op_class = CLS_JAL;    alu_cmd = ALU_CMD_W'(ALU_CMD_JUMP);                   end
      OP_JALR:   begin op_class = CLS_JALR;   alu_cmd = ALU_CMD_W'(ALU_CMD_JUMP);   alu_src = 1'b1; end
      default:   ;
    endcase
  end

  assign illegal = (op_class == CLS_ILLEGAL);

endmodule

// File: rtl/uc_multiciclo.sv
// Multicycle control FSM for the RV32I datapath: FETCH/DECODE/EXEC/MEM/WB with
// bus timeouts, a sticky trap and a retired-instruction counter.
module uc_multiciclo
  import uc_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter int ALU_CMD_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic [3:0]           alu_flags,
  input  logic                 i_mem_ack,
  input  logic                 d_mem_ack,
  output logic                 i_mem_req,
  output logic                 d_mem_req,
  output logic                 d_mem_we,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic                 rf_we,
  output logic [ALU_CMD_W-1:0] alu_cmd,
  output logic                 alu_src,
  output logic [1:0]           pc_src,
  output logic [1:0]           rf_src,
  output logic                 trap,
  output logic [CNT_W-1:0]     instret,
  output state_e               dbg_state
);

  // Handshake: a request is held high every cycle its state lasts; the ack is
  // sampled in the same cycle and the transfer completes on that clock edge.
  localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_e           state, next_state;
  op_class_e        op_class;
  logic [ALU_CMD_W-1:0] dec_cmd;
  logic             dec_src;
  logic             illegal;
  logic [TO_W-1:0]  to_cnt;
  logic             timeout_hit;
  logic             waiting;

  uc_decode #(.ALU_CMD_W(ALU_CMD_W)) u_decode (
    .opcode   (opcode),
    .op_class (op_class),
    .alu_cmd  (dec_cmd),
    .alu_src  (dec_src),
    .illegal  (illegal)
  );

  generate
    if (MEM_TIMEOUT > 0) begin : g_timeout
      assign timeout_hit = (to_cnt == TO_W'(MEM_TIMEOUT - 1));
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  // Counter is zero on entry to any bus-waiting state since every other state clears it.
  assign waiting = (state == FETCH && !i_mem_ack) || (state == MEM && !d_mem_ack);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= INIT;
      to_cnt  <= '0;
      instret <= '0;
    end else begin
      state  <= next_state;
      to_cnt <= waiting ? to_cnt + TO_W'(1) : '0;
      if (pc_we) instret <= instret + CNT_W'(1);
    end
  end

  always_comb begin
    next_state = state;
    i_mem_req  = 1'b0;
    d_mem_req  = 1'b0;
    d_mem_we   = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    rf_we      = 1'b0;
    pc_src     = PC_SRC_SEQ;
    rf_src     = RF_SRC_ALU;
    trap       = 1'b0;
    case (state)
      INIT: next_state = FETCH;
      FETCH: begin
        i_mem_req = 1'b1;
        if (i_mem_ack) begin
          ir_we      = 1'b1;
          next_state = DECODE;
        end else if (timeout_hit) begin
          next_state = TRAP;
        end
      end
      DECODE: next_state = illegal ? TRAP : EXEC;
      EXEC: begin
        case (op_class)
          CLS_BRANCH: begin
            pc_we      = 1'b1;
            pc_src     = alu_flags[0] ? PC_SRC_IMM : PC_SRC_SEQ;
            next_state = FETCH;
          end
          CLS_JAL, CLS_JALR: begin
            rf_we      = 1'b1;
            rf_src     = RF_SRC_PC4;
            pc_we      = 1'b1;
            pc_src     = (op_class == CLS_JAL) ? PC_SRC_IMM : PC_SRC_ALU;
            next_state = FETCH;
          end
          CLS_LOAD, CLS_STORE: next_state = MEM;
          default:             next_state = WB;
        endcase
      end
      MEM: begin
        d_mem_req = 1'b1;
        d_mem_we  = (op_class == CLS_STORE);
        if (d_mem_ack) begin
          if (op_class == CLS_STORE) begin
            pc_we      = 1'b1;
            next_state = FETCH;
          end else begin
            next_state = WB;
          end
        end else if (timeout_hit) begin
          next_state = TRAP;
        end
      end
      WB: begin
        rf_we      = 1'b1;
        pc_we      = 1'b1;
        rf_src     = (op_class == CLS_LOAD) ? RF_SRC_MEM : RF_SRC_ALU;
        next_state = FETCH;
      end
      TRAP: trap = 1'b1;
      default: next_state = INIT;
    endcase
  end

  assign alu_cmd   = (state == INIT) ? '0 : dec_cmd;
  assign alu_src   = (state == INIT) ? 1'b0 : dec_src;
  assign dbg_state = state;

endmodule

// File: tb/tb_uc_multiciclo.sv
// Self-checking bench for uc_multiciclo: directed and random instruction streams
// against a per-instruction cycle model, plus timeout, trap and reset cases.
module tb_uc_multiciclo;
  import uc_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = 7'b0;
  logic [3:0]  alu_flags = 4'b0;
  logic        i_mem_ack = 1'b0;
  logic        d_mem_ack = 1'b0;
  logic        i_mem_req, d_mem_req, d_mem_we, ir_we, pc_we, rf_we, alu_src, trap;
  logic [3:0]  alu_cmd;
  logic [1:0]  pc_src, rf_src;
  logic [31:0] instret;
  state_e      dbg_state;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] mdl_instret = 0;
  logic [6:0]  cur_op;
  string       cur_tag;
  // entry: [13]init [12]i_ack [11]d_ack [10]i_req [9]d_req [8]d_we [7]ir_we
  //        [6]pc_we [5]rf_we [4:3]pc_src [2:1]rf_src [0]trap
  logic [13:0] exp_q[$];

  uc_multiciclo #(.CNT_W(32), .MEM_TIMEOUT(TO), .ALU_CMD_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_flags(alu_flags),
    .i_mem_ack(i_mem_ack), .d_mem_ack(d_mem_ack), .i_mem_req(i_mem_req),
    .d_mem_req(d_mem_req), .d_mem_we(d_mem_we), .ir_we(ir_we), .pc_we(pc_we),
    .rf_we(rf_we), .alu_cmd(alu_cmd), .alu_src(alu_src), .pc_src(pc_src),
    .rf_src(rf_src), .trap(trap), .instret(instret), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // 0 R,1 I,2 LOAD,3 STORE,4 BRANCH,5 JAL,6 JALR,7 LUI,8 AUIPC,9 illegal
  function automatic int ref_class(input logic [6:0] op);
    case (op)
      7'b0110011: return 0;
      7'b0010011: return 1;
      7'b0000011: return 2;
      7'b0100011: return 3;
      7'b1100011: return 4;
      7'b1101111: return 5;
      7'b1100111: return 6;
      7'b0110111: return 7;
      7'b0010111: return 8;
      default:    return 9;
    endcase
  endfunction

  function automatic logic [4:0] ref_alu(input logic [6:0] op);
    case (ref_class(op))
      0: return {4'd0, 1'b0};
      1: return {4'd1, 1'b1};
      2, 3: return {4'd2, 1'b1};
      4: return {4'd3, 1'b0};
      5: return {4'd6, 1'b0};
      6: return {4'd6, 1'b1};
      7: return {4'd4, 1'b1};
      8: return {4'd5, 1'b1};
      default: return {4'd0, 1'b0};
    endcase
  endfunction

  function automatic logic [13:0] mk(input bit ini, input bit ia, input bit da,
      input bit ireq, input bit dreq, input bit dwe, input bit irw, input bit pcw,
      input bit rfw, input logic [1:0] ps, input logic [1:0] rs, input bit tr);
    return {ini, ia, da, ireq, dreq, dwe, irw, pcw, rfw, ps, rs, tr};
  endfunction

  task automatic push_trap(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(mk(0,0,0,0,0,0,0,0,0,2'b00,2'b00,1));
  endtask

  // Expected cycle-by-cycle behaviour of one instruction from its class and wait counts.
  task automatic build(input logic [6:0] op, input int iw, input int dw, input bit flag);
    int  cls;
    bit  st;
    cls = ref_class(op);
    st  = (cls == 3);
    cur_op = op;
    alu_flags = {3'b000, flag};
    if (iw >= TO) begin
      for (int k = 0; k < TO; k++) exp_q.push_back(mk(0,0,0,1,0,0,0,0,0,2'b00,2'b00,0));
      push_trap(22);
      return;
    end
    for (int k = 0; k <= iw; k++)
      exp_q.push_back(mk(0, k == iw, 0, 1, 0, 0, k == iw, 0, 0, 2'b00, 2'b00, 0));
    exp_q.push_back(mk(0,0,0,0,0,0,0,0,0,2'b00,2'b00,0));
    if (cls == 9) begin
      push_trap(22);
      return;
    end
    case (cls)
      4: exp_q.push_back(mk(0,0,0,0,0,0,0,1,0, flag ? 2'b01 : 2'b00, 2'b00, 0));
      5: exp_q.push_back(mk(0,0,0,0,0,0,0,1,1,2'b01,2'b10,0));
      6: exp_q.push_back(mk(0,0,0,0,0,0,0,1,1,2'b10,2'b10,0));
      2, 3: begin
        exp_q.push_back(mk(0,0,0,0,0,0,0,0,0,2'b00,2'b00,0));
        if (dw >= TO) begin
          for (int k = 0; k < TO; k++) exp_q.push_back(mk(0,0,0,0,1,st,0,0,0,2'b00,2'b00,0));
          push_trap(22);
          return;
        end
        for (int k = 0; k <= dw; k++)
          exp_q.push_back(mk(0, 0, k == dw, 0, 1, st, 0, st && (k == dw), 0, 2'b00, 2'b00, 0));
        if (!st) exp_q.push_back(mk(0,0,0,0,0,0,0,1,1,2'b00,2'b01,0));
      end
      default: begin
        exp_q.push_back(mk(0,0,0,0,0,0,0,0,0,2'b00,2'b00,0));
        exp_q.push_back(mk(0,0,0,0,0,0,0,1,1,2'b00,2'b00,0));
      end
    endcase
  endtask

  task automatic drain(input int n);
    logic [13:0] e;
    logic [10:0] obs;
    logic [4:0]  exp_alu;
    int done;
    done = 0;
    while (exp_q.size() > 0 && (n < 0 || done < n)) begin
      e = exp_q.pop_front();
      @(negedge clk);
      if (done == 0) opcode = cur_op;
      i_mem_ack = e[12];
      d_mem_ack = e[11];
      #1;
      obs = {i_mem_req, d_mem_req, d_mem_we, ir_we, pc_we, rf_we, pc_src, rf_src, trap};
      checks++;
      assert (obs === e[10:0]) else begin
        errors++;
        $error("FAIL %s cyc=%0d outputs obs=%b exp=%b", cur_tag, done, obs, e[10:0]);
      end
      checks++;
      assert (instret === mdl_instret) else begin
        errors++;
        $error("FAIL %s cyc=%0d instret obs=%0d exp=%0d", cur_tag, done, instret, mdl_instret);
      end
      exp_alu = e[13] ? 5'b0 : ref_alu(opcode);
      checks++;
      assert ({alu_cmd, alu_src} === exp_alu) else begin
        errors++;
        $error("FAIL %s cyc=%0d alu obs=%b exp=%b", cur_tag, done, {alu_cmd, alu_src}, exp_alu);
      end
      if (e[6]) mdl_instret = mdl_instret + 1;
      done++;
    end
  endtask

  task automatic run(input string tag, input logic [6:0] op, input int iw, input int dw,
                     input bit flag);
    cur_tag = tag;
    build(op, iw, dw, flag);
    drain(-1);
  endtask

  // Asserts reset away from a clock edge, checks the async clear, releases after a posedge.
  task automatic do_reset(input string tag);
    logic [10:0] obs;
    cur_tag = tag;
    exp_q.delete();
    #2 rst_n = 1'b0;
    i_mem_ack = 1'b0;
    d_mem_ack = 1'b0;
    #1;
    obs = {i_mem_req, d_mem_req, d_mem_we, ir_we, pc_we, rf_we, pc_src, rf_src, trap};
    mdl_instret = 0;
    checks++;
    assert (obs === 11'b0) else begin
      errors++; $error("FAIL %s rst_outputs obs=%b exp=%b", tag, obs, 11'b0);
    end
    checks++;
    assert (instret === 32'd0) else begin
      errors++; $error("FAIL %s rst_instret obs=%0d exp=0", tag, instret);
    end
    checks++;
    assert (dbg_state === INIT) else begin
      errors++; $error("FAIL %s rst_state obs=%0d exp=%0d", tag, dbg_state, INIT);
    end
    checks++;
    assert ({alu_cmd, alu_src} === 5'b0) else begin
      errors++; $error("FAIL %s rst_alu obs=%b exp=0", tag, {alu_cmd, alu_src});
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    cur_op = opcode;
    exp_q.push_back(mk(1,0,0,0,0,0,0,0,0,2'b00,2'b00,0));
    drain(-1);
  endtask

  logic [6:0] legal_ops [9];

  initial begin
    legal_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                  7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    do_reset("reset0");
    run("r_type",  7'b0110011, 0, 0, 0);
    run("load_w3", 7'b0000011, 0, 3, 0);
    run("br_take", 7'b1100011, 0, 0, 1);
    run("br_not",  7'b1100011, 1, 0, 0);
    run("jalr",    7'b1100111, 0, 0, 0);
    run("jal",     7'b1101111, 2, 0, 0);
    run("store",   7'b0100011, 0, 1, 0);
    run("lui",     7'b0110111, 0, 0, 0);
    run("auipc",   7'b0010111, 1, 0, 0);
    run("i_type",  7'b0010011, 0, 0, 0);
    run("fetch_ack_last", 7'b0110011, TO - 1, 0, 0);
    run("mem_ack_last",   7'b0100011, 0, TO - 1, 0);
    for (int i = 0; i < 60; i++)
      run("random", legal_ops[$urandom_range(0, 8)], $urandom_range(0, 3),
          $urandom_range(0, 3), 1'($urandom_range(0, 1)));

    run("fetch_timeout", 7'b0110011, TO, 0, 0);
    do_reset("reset1");
    run("illegal", 7'b1111111, 0, 0, 0);
    do_reset("reset2");
    run("mem_timeout", 7'b0000011, 1, TO, 0);
    do_reset("reset3");
    run("pre_mid", 7'b0010011, 0, 0, 0);
    cur_tag = "mid_mem";
    build(7'b0000011, 0, 3, 0);
    drain(5);
    do_reset("reset_mid_mem");
    run("after_reset", 7'b0110011, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
